// File: rtl/hazard3_uop_issue_ctrl.sv
// hazard3_uop_issue_ctrl
//
// Decode-stage issue controller for Zcmp micro-op expansion.
// This block sequences the decompressor through push/pop/popret/mvsa uop
// streams and issues one instruction or uop per cycle to execute.
// It also decides when an interrupt may be taken relative to a sequence,
// and reports how many CIR bytes each accepted issue consumes.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cir_vld               CIR holds a complete instruction
//   dc_*                  decompressor status for the current CIR contents
//   x_stall               execute cannot accept this cycle
//   flush                 flush from a later stage (top priority)
//   irq_req               enabled interrupt pending
//   uop_stall, uop_clear  uop counter controls back to the decompressor
//   d_vld, d_illegal      issue valid / issued instruction is illegal
//   d_irq_take            interrupt accepted this cycle (no issue)
//   d_mepc_restart        interrupt lands mid-sequence: restart the instruction
//   cir_use               CIR bytes consumed this cycle (0, 2 or 4)
//   seq_err               pulse: uop stream ran past UOP_MAX_LEN with no final uop
module hazard3_uop_issue_ctrl #(
    parameter int EXTENSION_ZCMP = 1,
    parameter int UOP_MAX_LEN    = 16,
    parameter int IRQ_IN_SEQ     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cir_vld,
    input  logic       dc_is_32bit,
    input  logic       dc_is_uop,
    input  logic       dc_is_final_uop,
    input  logic       dc_uop_atomic,
    input  logic       dc_uop_no_pc_update,
    input  logic       dc_invalid,
    input  logic       x_stall,
    input  logic       flush,
    input  logic       irq_req,
    output logic       uop_stall,
    output logic       uop_clear,
    output logic       d_vld,
    output logic       d_illegal,
    output logic       d_irq_take,
    output logic       d_mepc_restart,
    output logic [2:0] cir_use,
    output logic       seq_err
);

    localparam bit       ZCMP     = (EXTENSION_ZCMP != 0);
    localparam bit       IRQ_SEQ  = (IRQ_IN_SEQ != 0);
    localparam logic [3:0] CNT_LAST = 4'(UOP_MAX_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEQ    = 2'd1,
        S_ATOMIC = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] uop_cnt_q, uop_cnt_d;
    // Delayed counter clear after an overrun. The decompressor still holds
    // the runaway sequence, so it is reset one cycle after the error.
    logic       seq_clr_q;

    logic irq_window;
    logic accept;
    logic acc_ok;
    logic mid_uop;
    logic overrun;

    // PC advance is derived from cir_use elsewhere. The no-PC-update flag
    // is consumed by the PC logic, not by this sequencer.
    logic unused_no_pc_update;
    assign unused_no_pc_update = dc_uop_no_pc_update;

    assign mid_uop = dc_is_uop & ~dc_is_final_uop;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            uop_cnt_q <= 4'd0;
            seq_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            uop_cnt_q <= uop_cnt_d;
            seq_clr_q <= overrun;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!ZCMP) begin
            state_d = S_IDLE;
        end else if (flush || d_irq_take || overrun) begin
            state_d = S_IDLE;
        end else if (accept) begin
            // Illegal encodings, plain instructions and final uops all end
            // (or never start) a sequence.
            if (dc_invalid || !mid_uop) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE:   state_d = dc_uop_atomic ? S_ATOMIC : S_SEQ;
                    S_SEQ:    state_d = dc_uop_atomic ? S_ATOMIC : S_SEQ;
                    S_ATOMIC: state_d = S_ATOMIC;
                    default:  state_d = S_IDLE;
                endcase
            end
        end

        uop_cnt_d = uop_cnt_q;
        if (state_d == S_IDLE) begin
            uop_cnt_d = 4'd0;
        end else if (acc_ok && mid_uop && uop_cnt_q != 4'hf) begin
            uop_cnt_d = uop_cnt_q + 4'd1;
        end
    end

    // ---------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------
    always_comb begin
        // An interrupt may split a sequence only between interruptible
        // uops. Once an atomic uop has issued, it is held off until the
        // final uop retires the sequence.
        irq_window = (state_q == S_IDLE) || ((state_q == S_SEQ) && IRQ_SEQ);

        d_irq_take     = irq_req & cir_vld & ~x_stall & ~flush & irq_window;
        d_mepc_restart = d_irq_take & (state_q == S_SEQ);

        d_vld     = cir_vld & ~flush & ~d_irq_take;
        d_illegal = d_vld & dc_invalid;
        accept    = d_vld & ~x_stall;
        acc_ok    = accept & ~dc_invalid;

        overrun = ZCMP & acc_ok & mid_uop & (uop_cnt_q == CNT_LAST);
        seq_err = overrun;

        // Non-final uops leave the instruction in the CIR. Only the final
        // uop consumes the whole compressed instruction.
        cir_use = 3'd0;
        if (acc_ok && !mid_uop) begin
            cir_use = dc_is_32bit ? 3'd4 : 3'd2;
        end

        uop_clear = 1'b0;
        uop_stall = 1'b0;
        if (ZCMP) begin
            uop_clear = flush | d_irq_take | seq_clr_q;
            uop_stall = cir_vld & dc_is_uop & x_stall & ~uop_clear;
        end
    end

endmodule

// File: doc/hazard3_uop_issue_ctrl.md
Name: hazard3_uop_issue_ctrl

Overview:
- Decode-stage controller that sequences the instruction decompressor's micro-op (uop) expansion for Zcmp push/pop/popret/mvsa.
- Accepts decompressor status plus the current-instruction-register (CIR) valid flag. Issues one instruction or uop per cycle to the execute stage.
- Generates the decompressor's `uop_stall` and `uop_clear` controls and computes CIR consumption, in bytes.
- Arbitrates interrupt entry against uop sequences and honours atomic regions.

Parameters:
- EXTENSION_ZCMP, 1, when 0 the FSM is held in IDLE and `uop_stall`/`uop_clear` are tied 0. Plain instructions still issue normally.
- UOP_MAX_LEN, 16, uop count at which a sequence with no final uop is flagged as an error.
- IRQ_IN_SEQ, 1, when 1 interrupts may be taken between interruptible uops; when 0 only at instruction boundaries.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cir_vld  in  1  CIR holds a complete instruction
- dc_is_32bit  in  1  decompressor: uncompressed instruction
- dc_is_uop  in  1  decompressor: output is a uop
- dc_is_final_uop  in  1  decompressor: last uop of sequence
- dc_uop_atomic  in  1  decompressor: uop is in the noninterruptible tail
- dc_uop_no_pc_update  in  1  decompressor: PC must not advance
- dc_invalid  in  1  decompressor: illegal encoding
- x_stall  in  1  execute stage cannot accept this cycle
- flush  in  1  branch/exception flush from a later stage
- irq_req  in  1  enabled interrupt pending
- uop_stall  out  1  to decompressor: hold uop counter
- uop_clear  out  1  to decompressor: reset uop counter
- d_vld  out  1  issue valid to execute stage
- d_illegal  out  1  issued instruction is illegal
- d_irq_take  out  1  interrupt accepted this cycle; no instruction issues
- d_mepc_restart  out  1  with `d_irq_take`: interrupted mid-sequence, mepc = PC of the sequence instruction
- cir_use  out  3  bytes consumed from CIR: 0, 2 or 4
- seq_err  out  1  one-cycle pulse: sequence overran UOP_MAX_LEN

Behaviour:
- Reset: FSM=IDLE, uop_cnt=0, `seq_err`=0.
- All other outputs are combinational and evaluate to 0 while `cir_vld`=0 and `flush`=0.
- FSM states: IDLE (no sequence), SEQ (interruptible uops issued), ATOMIC (an atomic uop has issued).
- Issue: `d_vld` = `cir_vld` & ~`flush` & ~`d_irq_take`. The instruction/uop is accepted when `d_vld` & ~`x_stall`.
- `cir_use`, on accept only:
  - 0 if `dc_is_uop` & ~`dc_is_final_uop`;
  - else 4 if `dc_is_32bit`, else 2.
  - `cir_use` = 0 whenever not accepted.
- Illegal instruction: `d_illegal` = `d_vld` & `dc_invalid`; `cir_use`=0. An illegal instruction never enters SEQ/ATOMIC.
- `uop_stall` = `cir_vld` & `dc_is_uop` & `x_stall` & ~`uop_clear`.
- `uop_clear` = `flush` | `d_irq_take`. This is combinational and takes effect in the decompressor the same cycle.
- Interrupt acceptance: `d_irq_take` = `irq_req` & `cir_vld` & ~`x_stall` & ~`flush` & state≠ATOMIC, and additionally:
  - (state==IDLE) | (state==SEQ & IRQ_IN_SEQ).
  - In ATOMIC the interrupt is deferred until the final uop is accepted.
- `d_mepc_restart` = `d_irq_take` & (state==SEQ).
- Transitions, evaluated on accept:
  - from IDLE: if `dc_is_uop` & ~`dc_is_final_uop` → ATOMIC if `dc_uop_atomic`, else SEQ.
  - from SEQ: if `dc_uop_atomic` & ~final → ATOMIC.
  - final uop accepted → IDLE.
  - `d_irq_take` or `flush` → IDLE.
- `flush` has top priority over all events, including in ATOMIC (an exception in an earlier uop). There is no issue and no `cir_use` that cycle.
- uop_cnt (4 bit, saturating):
  - increments on each accepted non-final uop;
  - cleared on IDLE entry.
- If uop_cnt reaches UOP_MAX_LEN-1 and another non-final uop is accepted:
  - `seq_err` pulses for one cycle;
  - the FSM forces IDLE;
  - `uop_clear` asserts the next cycle.
- Simultaneous events:
  - `flush` & `irq_req` → flush only (`d_irq_take`=0).
  - `x_stall` & `irq_req` → nothing taken; retry next cycle.
- Reset mid-sequence: immediate return to IDLE. The decompressor resets independently.

Test Plan:
- Plain 16-bit then 32-bit instruction, no stall → `d_vld`=1 both cycles, `cir_use`=2 then 4, FSM stays IDLE.
- `cm.push` with 3 uops (2×sw + addi), `x_stall` high for 2 cycles on uop 1:
  - `uop_stall`=1 for exactly those 2 cycles;
  - `cir_use`=0,0,2 on the three accepts;
  - FSM IDLE→SEQ→SEQ→IDLE.
- `irq_req` raised after the first lw of `cm.pop`:
  - next cycle `d_irq_take`=1, `d_mepc_restart`=1, `uop_clear`=1, `d_vld`=0, `cir_use`=0, FSM→IDLE.
- `cm.popretz`, `irq_req` asserted once the jalr (atomic) uop is accepted:
  - `d_irq_take` stays 0 until the final addi is accepted (`cir_use`=2);
  - the next cycle `d_irq_take`=1 with `d_mepc_restart`=0.
- `flush` with FSM in ATOMIC → same cycle `uop_clear`=1, `d_vld`=0; next cycle FSM=IDLE, uop_cnt=0.
- `dc_invalid`=1 (encoding 0x0000) → `d_vld`=1, `d_illegal`=1, `cir_use`=0, FSM stays IDLE. Also a 16-uop non-final stream → `seq_err` pulse on the 16th accept.
